// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the countdown timer: FSM state
//               encoding and default counter/prescaler widths.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  localparam int unsigned c_DEF_WIDTH       = 32;
  localparam int unsigned c_DEF_PRESC_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Clock divider producing a one-cycle tick every
//               i_prescale+1 counted cycles. The count is held while i_hold
//               is high and restarted from zero by i_clear.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               i_clear      - restart division from zero
//               i_hold       - freeze the divider (no tick while high)
//               i_prescale   - divide ratio minus one
//               o_tick       - one-cycle tick output
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_hold,
  input  logic [WIDTH-1:0] i_prescale,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_wrap;

  // >= rather than == keeps the divider bounded whatever r_cnt holds.
  assign w_wrap = (r_cnt >= i_prescale);
  assign o_tick = !i_hold && w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Programmable countdown timer with one-shot / auto-reload
//               modes, pause, sticky interrupt and overrun flags.
//               Optional feature macro: TIMER_PRESCALER_EN - when defined a
//               tick_prescaler divides the count rate by prescale_i+1
//               (sampled with start_i); otherwise every RUN cycle is a tick.
// Ports       : clk_i, rst_i   - clock, asynchronous active-high reset
//               start_i        - load period_i / periodic_i and run
//               stop_i         - abort countdown without expiry
//               pause_i        - freeze countdown while high
//               periodic_i     - 1 = auto-reload, 0 = one-shot
//               period_i       - countdown length in ticks
//               prescale_i     - tick divider (macro builds only)
//               irq_ack_i      - clears irq_o and overrun_o
//               count_o        - remaining ticks
//               busy_o         - RUN or PAUSED
//               expired_o      - one-cycle expiry pulse
//               irq_o          - sticky expiry flag
//               overrun_o      - sticky expiry-while-irq flag
//               cfg_err_o      - one-cycle pulse on start with period 0
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH       = c_DEF_WIDTH,
  parameter int unsigned PRESC_WIDTH = c_DEF_PRESC_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   pause_i,
  input  logic                   periodic_i,
  input  logic [WIDTH-1:0]       period_i,
  input  logic [PRESC_WIDTH-1:0] prescale_i,
  input  logic                   irq_ack_i,
  output logic [WIDTH-1:0]       count_o,
  output logic                   busy_o,
  output logic                   expired_o,
  output logic                   irq_o,
  output logic                   overrun_o,
  output logic                   cfg_err_o
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_period;
  logic             r_periodic;
  logic             r_expired;
  logic             r_irq;
  logic             r_overrun;
  logic             r_cfg_err;

  logic             w_start_ok;
  logic             w_start_bad;
  logic             w_run_cycle;
  logic             w_tick;
  logic             w_expire;

  // stop_i outranks start_i, so a start accompanied by a stop is ignored.
  assign w_start_ok  = start_i && !stop_i && (period_i != '0);
  assign w_start_bad = start_i && !stop_i && (period_i == '0);

  // A cycle may count only when no higher-priority request is present.
  assign w_run_cycle = (r_state == ST_RUN) && !stop_i && !start_i && !pause_i;

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_WIDTH-1:0] r_prescale;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prescale <= '0;
    end else if (w_start_ok) begin
      r_prescale <= prescale_i;
    end
  end

  tick_prescaler #(
    .WIDTH (PRESC_WIDTH)
  ) u_tick_prescaler (
    .clk        (clk_i),
    .rst        (rst_i),
    .i_clear    (w_start_ok),
    .i_hold     (!w_run_cycle),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );
`else
  logic w_unused_prescale;
  assign w_unused_prescale = ^prescale_i;
  assign w_tick            = w_run_cycle;
`endif

  // Next-state / next-count decode in priority order stop > start > pause > tick.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_expire    = 1'b0;
    if (stop_i) begin
      if (r_state != ST_IDLE) begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    end else if (start_i) begin
      if (period_i != '0) begin
        w_state_nxt = ST_RUN;
        w_count_nxt = period_i;
      end
    end else if ((r_state == ST_RUN) && pause_i) begin
      w_state_nxt = ST_PAUSED;
    end else if ((r_state == ST_PAUSED) && !pause_i) begin
      w_state_nxt = ST_RUN;
    end else if (w_tick) begin
      if (r_count > c_ONE) begin
        w_count_nxt = r_count - c_ONE;
      end else begin
        // Count of one (zero cannot occur in RUN) ends this period.
        w_expire = 1'b1;
        if (r_periodic) begin
          w_count_nxt = r_period;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_period   <= '0;
      r_periodic <= 1'b0;
      r_expired  <= 1'b0;
      r_irq      <= 1'b0;
      r_overrun  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_expired <= w_expire;
      r_cfg_err <= w_start_bad;
      if (w_start_ok) begin
        r_period   <= period_i;
        r_periodic <= periodic_i;
      end
      // A fresh expiry wins over a same-cycle ack for irq, but the ack
      // still clears any overrun.
      if (w_expire) begin
        r_irq <= 1'b1;
      end else if (irq_ack_i) begin
        r_irq <= 1'b0;
      end
      if (irq_ack_i) begin
        r_overrun <= 1'b0;
      end else if (w_expire && r_irq) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign count_o   = r_count;
  assign busy_o    = (r_state != ST_IDLE);
  assign expired_o = r_expired;
  assign irq_o     = r_irq;
  assign overrun_o = r_overrun;
  assign cfg_err_o = r_cfg_err;

endmodule : countdown_timer
`default_nettype wire
